// File: rtl/sipo_receiver.sv
// Serial-in / parallel-out receiver: shifts N bits MSB first on enabled edges,
// then presents the completed word on data with a one-cycle valid pulse.
module sipo_receiver #(
    parameter int N = 8
) (
    input  logic                       Clock,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic                       serin,
    output logic [N-1:0]               data,
    output logic                       valid,
    output logic                       busy,
    output logic [$clog2(N+1)-1:0]     bit_cnt
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   shreg;
    logic           last_bit;

    assign last_bit = en && (bit_cnt == CW'(N - 1));

    // NOTE: every state register is written with <= so all flops update
    // together from pre-edge values; blocking = here would create ordering races.
    always_ff @(posedge Clock) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            // Flags are decoded from the next state so they leave a flop,
            // giving no combinational path from any input to an output.
            valid <= (state_next == DONE);
            busy  <= (state_next == SHIFT);
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            shreg   <= '0;
            data    <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // start is deliberately not looked at here: a word in
                    // flight can't be restarted.
                    if (en) begin
                        shreg   <= {shreg[N-2:0], serin};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            data <= {shreg[N-2:0], serin};
                        end
                    end
                end
                DONE: begin
                    // Leaving DONE always starts from a clean word, whether
                    // heading to IDLE or straight into the next SHIFT.
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
                default: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width in bits (N >= 2).
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  bit-sample enable; a serial bit is taken only on edges where en=1.
REQ-005 SHALL have port start  input  1  begin word reception (single-cycle pulse or level).
REQ-006 SHALL have port serin  input  1  serial data bit, MSB first.
REQ-007 SHALL have port data  output  N  last completed parallel word.
REQ-008 SHALL have port valid  output  1  high for exactly one cycle when data is updated.
REQ-009 SHALL have port busy  output  1  high while a word is being shifted in.
REQ-010 SHALL have port bit_cnt  output  clog2(N+1)  number of bits captured in the current word.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered; no combinational input-to-output path.
REQ-012 IDLE: busy=0, valid=0; start=1 at an edge -> SHIFT, shift register cleared to 0, bit_cnt=0; en and serin ignored in IDLE.
REQ-013 SHIFT: busy=1; edge with en=1 -> shreg <= {shreg[N-2:0], serin}, bit_cnt += 1; edge with en=0 -> shreg and bit_cnt hold.
REQ-014 SHIFT: edge with en=1 and bit_cnt=N-1 -> data <= {shreg[N-2:0], serin}, state -> DONE, bit_cnt <= N.
REQ-015 start SHALL be ignored in SHIFT (no restart, no counter clear).
REQ-016 DONE: valid=1, busy=0, lasts exactly one cycle; next edge -> IDLE, bit_cnt=0, unless start=1, then -> SHIFT with shreg and bit_cnt cleared (back-to-back words, no idle gap).
REQ-017 Latency: valid SHALL be high in the cycle immediately after the edge sampling the Nth bit; data SHALL be stable from that cycle until the next word completes.
REQ-018 data SHALL change only on the completing edge of REQ-014 or on reset.
REQ-019 bit_cnt SHALL never exceed N and SHALL not wrap.
REQ-020 serin SHALL be sampled only at the rising edge of Clock; glitches between edges have no effect.

Reset
REQ-021 rst=1 at an edge SHALL override all other inputs: state=IDLE, data=0, valid=0, busy=0, bit_cnt=0, shreg=0.
REQ-022 Reset mid-word (SHIFT or DONE) SHALL discard the partial word; no valid pulse SHALL follow.
REQ-023 The first edge with rst=0 SHALL apply IDLE rules (start honoured on that edge).

Verification
REQ-024 N=8, start pulse, en=1 continuous, serin=1,0,1,0,0,1,0,1 -> valid=1 one cycle after 8th bit, data=8'hA5, busy falls with valid rise, bit_cnt 1..8.
REQ-025 N=8, en toggling 1,0,1,0... while sending 8'h3C -> bit_cnt advances only on en=1 edges, data=8'h3C after 8 enabled edges, valid width exactly 1 cycle.
REQ-026 Send 8'hFF, then rst=1 after 3 enabled bits -> next cycle data=8'h00, busy=0, bit_cnt=0, valid never asserts.
REQ-027 Send 8'h3C, start=1 during DONE, then send 8'hC3 -> two valid pulses separated by exactly 8 enabled cycles, data=8'h3C then 8'hC3, no IDLE cycle between.
REQ-028 start=1 asserted again mid-word (after 4 bits of 8'h5A) -> ignored, data=8'h5A on completion; en=1 with serin activity in IDLE -> bit_cnt=0, data unchanged.
